// File: rtl/mant_lzc_norm_pipe.sv
// ---------------------------------------------------------------------------
// mant_lzc_norm_pipe
//
// Two-stage normalization controller for the FP multiply datapath. Stage 1
// registers the unnormalized mantissa and biased exponent. Stage 2 counts
// leading zeros, clamps the shift against the exponent for gradual underflow
// and registers mantissa, shift amount and adjusted exponent for the 24-bit
// barrel left shifter that follows.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   in_valid/in_ready   input handshake (in_ready combinational from out_ready)
//   mant_in[23:0]       unnormalized mantissa, bit 23 = hidden-bit position
//   exp_in[EXP_W-1:0]   biased exponent
//   out_valid/out_ready output handshake
//   mant_out[23:0]      registered mant_in, unshifted (shifter data input)
//   nshiftleft[4:0]     left shift amount 0..23 (shifter shift input)
//   exp_out[EXP_W-1:0]  adjusted biased exponent
//   zero                mantissa was all zeros
//   underflow           shift was clamped by the exponent (denormal result)
//   uf_count[15:0]      saturating count of underflow output transfers
//                       (present only when LZC_UNDERFLOW_CNT_EN is defined)
//
// Parameter: EXP_W, biased exponent width, valid for 5..11.
// ---------------------------------------------------------------------------
module mant_lzc_norm_pipe #(
    parameter int unsigned EXP_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [23:0]      mant_in,
    input  logic [EXP_W-1:0] exp_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [23:0]      mant_out,
    output logic [4:0]       nshiftleft,
    output logic [EXP_W-1:0] exp_out,
    output logic             zero,
    output logic             underflow
`ifdef LZC_UNDERFLOW_CNT_EN
    ,
    output logic [15:0]      uf_count
`endif
);

    // Comparison width: wide enough for both the exponent and the 0..24 count.
    localparam int unsigned CW = (EXP_W > 5) ? EXP_W : 5;

    // Balanced leading-zero counter. The mantissa is padded with eight ones
    // to 32 bits so the tree is a clean 5-level binary reduction and the
    // all-zero mantissa naturally yields 24. Each merge takes the left count
    // unless the left half is all zero, in which case it prefixes a 1 to the
    // right count. Nodes are reduced in place: node j reads 2j and 2j+1, which
    // are never already overwritten at that point.
    function automatic logic [4:0] lzc24(input logic [23:0] m);
        logic [31:0] x;
        logic [4:0]  cnt [0:31];
        logic        zf  [0:31];
        logic [4:0]  c_new;
        logic        z_new;
        x = {m, 8'hFF};
        for (int unsigned i = 0; i < 32; i++) begin
            zf[i]  = ~x[31 - i];
            cnt[i] = '0;
        end
        for (int unsigned l = 0; l < 5; l++) begin
            for (int unsigned j = 0; j < (32 >> (l + 1)); j++) begin
                c_new  = zf[2*j] ? ((5'd1 << l) | cnt[2*j + 1]) : cnt[2*j];
                z_new  = zf[2*j] & zf[2*j + 1];
                cnt[j] = c_new;
                zf[j]  = z_new;
            end
        end
        return cnt[0];
    endfunction

    logic             s1_valid;
    logic [23:0]      s1_mant;
    logic [EXP_W-1:0] s1_exp;

    logic             s2_adv;
    logic             s1_adv;

    logic [4:0]       lz;
    logic [CW-1:0]    e_ext;
    logic [CW-1:0]    lz_ext;
    logic [4:0]       nsl_n;
    logic [EXP_W-1:0] exp_n;
    logic             zero_n;
    logic             uf_n;

    always_comb begin
        s2_adv   = !out_valid || out_ready;
        s1_adv   = !s1_valid || s2_adv;
        in_ready = s1_adv;
    end

    // Stage 2 arithmetic on zero-extended values.
    always_comb begin
        lz     = lzc24(s1_mant);
        e_ext  = CW'(s1_exp);
        lz_ext = CW'(lz);
        nsl_n  = '0;
        exp_n  = '0;
        zero_n = 1'b0;
        uf_n   = 1'b0;
        if (s1_mant == '0) begin
            zero_n = 1'b1;
        end else if (e_ext > lz_ext) begin
            nsl_n = lz;
            exp_n = EXP_W'(e_ext - lz_ext);
        end else if (e_ext != '0) begin
            // exp <= lz <= 23 here, so exp-1 always fits in 5 bits.
            nsl_n = 5'(e_ext - CW'(1));
            uf_n  = 1'b1;
        end else begin
            uf_n = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_mant  <= '0;
            s1_exp   <= '0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_mant <= mant_in;
                s1_exp  <= exp_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            mant_out   <= '0;
            nshiftleft <= '0;
            exp_out    <= '0;
            zero       <= 1'b0;
            underflow  <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                mant_out   <= s1_mant;
                nshiftleft <= nsl_n;
                exp_out    <= exp_n;
                zero       <= zero_n;
                underflow  <= uf_n;
            end
        end
    end

`ifdef LZC_UNDERFLOW_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            uf_count <= '0;
        end else if (out_valid && out_ready && underflow && (uf_count != '1)) begin
            uf_count <= uf_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mant_lzc_norm_pipe.sv
// ---------------------------------------------------------------------------
// tb_mant_lzc_norm_pipe
//
// Scoreboard bench for mant_lzc_norm_pipe (EXP_W = 8). Accepted inputs push
// the reference result into a queue; a monitor pops and compares on every
// output transfer and also checks that outputs hold while stalled.
// Optional uf_count (LZC_UNDERFLOW_CNT_EN) is checked when that macro is set.
// ---------------------------------------------------------------------------
module tb_mant_lzc_norm_pipe;

    localparam int unsigned EXP_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [23:0]      mant_in;
    logic [EXP_W-1:0] exp_in;
    logic             out_valid;
    logic             out_ready;
    logic [23:0]      mant_out;
    logic [4:0]       nshiftleft;
    logic [EXP_W-1:0] exp_out;
    logic             zero;
    logic             underflow;
`ifdef LZC_UNDERFLOW_CNT_EN
    logic [15:0]      uf_count;
`endif

    always #5 clk = ~clk;

    mant_lzc_norm_pipe #(.EXP_W(EXP_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .mant_in    (mant_in),
        .exp_in     (exp_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .mant_out   (mant_out),
        .nshiftleft (nshiftleft),
        .exp_out    (exp_out),
        .zero       (zero),
        .underflow  (underflow)
`ifdef LZC_UNDERFLOW_CNT_EN
        ,
        .uf_count   (uf_count)
`endif
    );

    typedef struct packed {
        logic [23:0]      mant;
        logic [4:0]       nsl;
        logic [EXP_W-1:0] e;
        logic             zero;
        logic             uf;
    } res_t;

    res_t exp_q[$];
    int   n_checks  = 0;
    int   n_fail    = 0;
    int   acc_count = 0;
    int   out_count = 0;
    int   model_uf  = 0;
    bit   rand_mode = 0;

    // Reference: leading zeros by plain bit search, then the clamp rules.
    function automatic res_t model(input logic [23:0] m, input logic [EXP_W-1:0] e);
        res_t r;
        int   lz;
        int   ev;
        r.mant = m;
        r.nsl  = '0;
        r.e    = '0;
        r.zero = 1'b0;
        r.uf   = 1'b0;
        lz = 24;
        for (int b = 0; b < 24; b++) if (m[b]) lz = 23 - b;
        ev = int'(e);
        if (m == 24'd0) begin
            r.zero = 1'b1;
        end else if (ev > lz) begin
            r.nsl = 5'(lz);
            r.e   = EXP_W'(ev - lz);
        end else if (ev > 0) begin
            r.nsl = 5'(ev - 1);
            r.uf  = 1'b1;
        end else begin
            r.uf = 1'b1;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [23:0] gen_mant();
        logic [23:0] m;
        int          sh;
        m  = 24'($urandom);
        sh = $urandom_range(0, 26);
        return (sh >= 24) ? 24'd0 : (m >> sh);
    endfunction

    function automatic logic [EXP_W-1:0] gen_exp();
        case ($urandom_range(0, 2))
            0:       return EXP_W'($urandom_range(0, 25));
            1:       return EXP_W'($urandom);
            default: return EXP_W'($urandom_range(20, 40));
        endcase
    endfunction

    // Single input with the pipeline drained and out_ready=1; checks that the
    // result appears exactly two edges after it is offered.
    task automatic send_lat(input logic [23:0] m, input logic [EXP_W-1:0] e);
        @(posedge clk); #1;
        mant_in  = m;
        exp_in   = e;
        in_valid = 1'b1;
        @(negedge clk);
        check("lat_in_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("lat_edge1_out_valid", out_valid, 0);
        @(negedge clk);
        check("lat_edge2_out_valid", out_valid, 1);
    endtask

    // Offers n random items, optionally with random idle gaps; each wait for
    // acceptance is bounded.
    task automatic stream(input int n, input bit gaps);
        int t;
        int gap;
        for (int k = 0; k < n; k++) begin
            gap = gaps ? $urandom_range(0, 2) : 0;
            if (gap > 0) begin
                in_valid = 1'b0;
                repeat (gap) @(posedge clk);
                #1;
            end
            mant_in  = gen_mant();
            exp_in   = gen_exp();
            in_valid = 1'b1;
            t = 0;
            @(negedge clk);
            while (!in_ready && t < 200) begin
                t++;
                @(negedge clk);
            end
            if (!in_ready) begin
                n_checks++;
                n_fail++;
                $display("FAIL accept_timeout: got in_ready=0, expected 1 within 200 cycles");
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    initial begin
        res_t        r;
        res_t        held;
        bit          held_valid;
        int          base;
        int          c0;
        int          t;

        rst       = 1'b1;
        in_valid  = 1'b0;
        mant_in   = '0;
        exp_in    = '0;
        out_ready = 1'b0;
        held_valid = 1'b0;

        fork
            // Monitor: scoreboard pop/compare and stall-hold check.
            forever begin
                @(negedge clk);
                if (rst) begin
                    held_valid = 1'b0;
                end else begin
                    if (in_valid && in_ready) begin
                        exp_q.push_back(model(mant_in, exp_in));
                        acc_count++;
                    end
                    if (held_valid && out_valid)
                        check("stall_hold", {mant_out, nshiftleft, exp_out, zero, underflow}, held);
                    held_valid = out_valid && !out_ready;
                    held       = {mant_out, nshiftleft, exp_out, zero, underflow};
                    if (out_valid && out_ready) begin
                        out_count++;
                        if (exp_q.size() == 0) begin
                            n_checks++;
                            n_fail++;
                            $display("FAIL unexpected_output: got mant_out=%0h, expected no output", mant_out);
                        end else begin
                            r = exp_q.pop_front();
                            check("result", {mant_out, nshiftleft, exp_out, zero, underflow}, r);
                            if (r.uf) model_uf++;
                        end
                    end
                end
            end
            forever begin
                @(posedge clk); #1;
                if (rand_mode) out_ready = ($urandom_range(0, 3) != 0);
            end
            begin
                #2000000;
                $display("FAIL watchdog: got no completion, expected finish before time limit");
                $fatal(1, "watchdog");
            end
        join_none

        // Reset
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_mant_out", mant_out, 0);
        check("rst_nshiftleft", nshiftleft, 0);
        check("rst_exp_out", exp_out, 0);
        check("rst_zero", zero, 0);
        check("rst_underflow", underflow, 0);

        // Directed vectors
        out_ready = 1'b1;
        send_lat(24'h000F00, 8'd130);
        send_lat(24'h000001, 8'd5);
        send_lat(24'h400000, 8'd0);
        send_lat(24'h000000, 8'd90);
        send_lat(24'h800000, 8'd1);
        send_lat(24'h000001, 8'd24);

        // Back-pressure: five back-to-back items into a blocked pipeline.
        @(posedge clk); #1;
        out_ready = 1'b0;
        base = acc_count;
        fork
            stream(5, 1'b0);
            begin
                repeat (8) @(posedge clk);
                #1;
                check("bp_in_ready_low", in_ready, 0);
                check("bp_accepted", acc_count - base, 2);
                c0 = out_count;
                out_ready = 1'b1;
                repeat (5) @(posedge clk);
                #1;
                check("bp_throughput", out_count - c0, 5);
            end
        join
        check("bp_total", acc_count - base, 5);

        // Reset with data in flight.
        @(posedge clk); #1;
        mant_in  = 24'h00ABCD;
        exp_in   = 8'd50;
        in_valid = 1'b1;
        @(posedge clk); #1;
        mant_in  = 24'h000003;
        exp_in   = 8'd7;
        @(posedge clk); #1;
        rst      = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        model_uf = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("post_rst_no_output", out_valid, 0);
        end

        // Three underflow results.
        send_lat(24'h000001, 8'd3);
        send_lat(24'h000100, 8'd2);
        send_lat(24'h00FFFF, 8'd0);
        @(negedge clk);
        check("uf_model_count", model_uf, 3);
`ifdef LZC_UNDERFLOW_CNT_EN
        check("uf_count_three", uf_count, 3);
`endif

        // Randomized traffic with random back-pressure.
        rand_mode = 1'b1;
        stream(300, 1'b1);
        rand_mode = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        t = 0;
        while (exp_q.size() != 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        check("drain_queue_empty", exp_q.size(), 0);
        check("drain_out_valid", out_valid, 0);
`ifdef LZC_UNDERFLOW_CNT_EN
        check("uf_count_final", uf_count, (model_uf > 65535) ? 65535 : model_uf);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mant_lzc_norm_pipe.md
Name: mant_lzc_norm_pipe

Overview:
- Two-stage pipelined normalization controller in the FP multiply datapath.
- Accepts a 24-bit unnormalized mantissa and a biased exponent. Counts leading zeros, clamps the shift against the exponent for gradual underflow, and emits the mantissa, a 5-bit shift amount and the adjusted exponent.
- Feeds the 24-bit barrel left shifter directly: nshiftleft drives the shifter's shift input; mant_out drives its data input.
- Valid/ready handshake on both sides, with full-throughput back-pressure.

Parameters:
- EXP_W, 8, biased exponent width (8 for single precision); the block must be correct for 5..11.

Ports:
- clk  input  1  clock, all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  upstream holds mant_in/exp_in valid
- in_ready  output  1  block accepts the input this cycle
- mant_in  input  24  unnormalized mantissa, bit 23 = hidden-bit position
- exp_in  input  EXP_W  biased exponent of mant_in
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts the result
- mant_out  output  24  mant_in passed through unshifted
- nshiftleft  output  5  left shift amount, 0..23
- exp_out  output  EXP_W  adjusted biased exponent
- zero  output  1  mant_in was all zeros
- underflow  output  1  shift was clamped by the exponent (denormal result)

Behaviour:
- Reset (rst=1 at an edge): both stage valid bits cleared. out_valid=0; mant_out, nshiftleft, exp_out, zero, underflow all 0. in_ready is 1 in the first cycle after reset.
- Reset mid-operation: in-flight data is discarded; no output is produced for it.
- Transfers: input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
- Stage 1 registers mant_in/exp_in.
- Stage 2 computes and registers all results.
- Latency: an input accepted at edge N appears with out_valid=1 after edge N+2. No combinational path from in_* to out_*.
- Stall rules:
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv. This is combinational from out_ready; no skid buffer is required.
  - Throughput: 1 transfer per cycle when out_ready is held high.
- Stage contents are held unchanged while stalled. Output fields must not change while out_valid=1 && !out_ready.
- Full pipeline with out_ready=0: in_ready=0. An input offered then must not be captured.
- Simultaneous out transfer and in transfer in the same cycle: both occur and nothing is lost or duplicated.
- Arithmetic, stage 2, with lz = count of leading zeros of the 24-bit mantissa (0..24):
  - mant==0: zero=1, nshiftleft=0, exp_out=0, underflow=0.
  - exp > lz: nshiftleft=lz, exp_out=exp-lz, underflow=0.
  - 0 < exp <= lz: nshiftleft=exp-1, exp_out=0, underflow=1.
  - exp==0, mant!=0: nshiftleft=0, exp_out=0, underflow=1.
- mant_out always equals the registered mant_in.
- Comparisons are on zero-extended values of width max(EXP_W,5). nshiftleft is never above 23.
- The LZC must be a balanced priority encoder, not a serial scan.

Optional Feature:
- Macro: LZC_UNDERFLOW_CNT_EN
- Defined: adds output port uf_count[15:0].
  - Increments by 1 on each output transfer with underflow=1.
  - Saturates at 16'hFFFF; cleared by rst.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
- Reset check: rst high 2 cycles, then low. Required: out_valid=0, in_ready=1, all outputs 0.
- Normal case: mant_in=24'h000F00, exp_in=8'd130, out_ready=1. Two edges later: nshiftleft=12, exp_out=118, zero=0, underflow=0, mant_out=24'h000F00.
- Underflow clamp: mant_in=24'h000001, exp_in=8'd5. Required: nshiftleft=4, exp_out=0, underflow=1.
- Exponent zero: mant_in=24'h400000, exp_in=0. Required: nshiftleft=0, exp_out=0, underflow=1.
- Zero mantissa: mant_in=0, exp_in=8'd90. Required: zero=1, nshiftleft=0, exp_out=0, underflow=0.
- Back-pressure:
  - Stream 5 back-to-back inputs with out_ready=0. in_ready drops after 2 accepted; outputs stay stable.
  - Raise out_ready. All 5 results emerge in order with no loss or duplicates, 1 per cycle.
  - Assert rst mid-stream: no stale output appears afterwards.
  - With LZC_UNDERFLOW_CNT_EN defined, 3 underflow results give uf_count=3.
